// File: rtl/obstacle_spawn_scheduler_pkg.sv
// Shared definitions for the obstacle spawn scheduler.
// Holds the slot count, x width, FSM state encoding and the gap/level pacing
// constants, plus two small index helpers used by the top level.
package obstacle_spawn_scheduler_pkg;

    localparam int N_OBS = 6;
    localparam int X_W   = 8;
    localparam int PTR_W = 3;

    localparam logic [7:0] START_GAP    = 8'd64;
    localparam logic [7:0] MIN_GAP      = 8'd16;
    localparam logic [7:0] GAP_STEP     = 8'd4;
    localparam logic [3:0] LEVEL_SPAWNS = 4'd8;
    localparam logic [3:0] RETRY_MAX    = 4'd15;
    localparam logic [3:0] LEVEL_MAX    = 4'd15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COOLDOWN = 2'd1,
        ARMED    = 2'd2,
        SPAWN    = 2'd3
    } state_e;

    // Index of the set bit of a one-hot slot vector (0 when empty).
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_OBS-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_OBS; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

    // Slot index plus one, wrapping the last slot back to 0.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_OBS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/obstacle_spawn_scheduler_rr_free_slot_picker.sv
// Combinational round-robin free-slot finder.
// Searches obstacle_on for the first inactive slot starting at rr_ptr and
// wrapping from the last slot to slot 0.
//   obstacle_on : per-slot active flags
//   rr_ptr      : slot index where the search starts
//   found       : at least one slot is free
//   grant       : one-hot of the chosen free slot (0 when none)
module obstacle_spawn_scheduler_rr_free_slot_picker
    import obstacle_spawn_scheduler_pkg::*;
(
    input  logic [N_OBS-1:0] obstacle_on,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             found,
    output logic [N_OBS-1:0] grant
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < N_OBS; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % N_OBS);
            if (!found && !obstacle_on[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// Obstacle spawn scheduler: paces creation of obstacles in a six-slot pool.
// Waits a frame-based cooldown, then picks a free slot round-robin and an x
// position from the random word, refusing positions in the same horizontal
// bucket as the previous spawn (up to a retry limit). Every LEVEL_SPAWNS
// spawns the level rises and the cooldown gap shrinks toward MIN_GAP.
//   clk, reset    : clock, synchronous active-high reset
//   on            : game running; low clears all state like reset
//   upsig         : one-clk frame tick
//   q             : free-running random word (bits [6:0] used)
//   obstacle_on   : per-slot active flags from the pool
//   init_obstacle : one-hot, one-cycle spawn strobe
//   initial_x     : x position of the latest spawn, held between spawns
//   level         : current difficulty level
//   busy_stall    : armed but every slot is occupied
//
// init_obstacle is a strobe with no back-pressure: the pool must capture it
// together with initial_x in the cycle it is high. The FSM state is kept in
// state_q for observation.
module obstacle_spawn_scheduler
    import obstacle_spawn_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             on,
    input  logic             upsig,
    input  logic [18:0]      q,
    input  logic [N_OBS-1:0] obstacle_on,
    output logic [N_OBS-1:0] init_obstacle,
    output logic [X_W-1:0]   initial_x,
    output logic [3:0]       level,
    output logic             busy_stall
);

    state_e           state_q, state_d;
    logic [7:0]       gap_q, gap_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [3:0]       spawn_cnt_q, spawn_cnt_d;
    logic [3:0]       level_q, level_d;
    logic [3:0]       retry_q, retry_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [2:0]       last_bucket_q, last_bucket_d;
    logic [2:0]       spawn_bucket_q, spawn_bucket_d;
    logic [N_OBS-1:0] slot_oh_q, slot_oh_d;
    logic [X_W-1:0]   initial_x_q, initial_x_d;

    logic             found;
    logic [N_OBS-1:0] grant;
    logic [X_W-1:0]   cand_x;
    logic [2:0]       cand_bucket;
    logic             run;
    logic             unused_q_bits;

    assign cand_x        = X_W'({1'b0, q[6:0]});
    assign cand_bucket   = q[6:4];
    assign unused_q_bits = ^q[18:7];
    assign run           = on && !reset;

    obstacle_spawn_scheduler_rr_free_slot_picker u_picker (
        .obstacle_on (obstacle_on),
        .rr_ptr      (rr_ptr_q),
        .found       (found),
        .grant       (grant)
    );

    always_comb begin
        state_d        = state_q;
        gap_d          = gap_q;
        frame_cnt_d    = frame_cnt_q;
        spawn_cnt_d    = spawn_cnt_q;
        level_d        = level_q;
        retry_d        = retry_q;
        rr_ptr_d       = rr_ptr_q;
        last_bucket_d  = last_bucket_q;
        spawn_bucket_d = spawn_bucket_q;
        slot_oh_d      = slot_oh_q;
        initial_x_d    = initial_x_q;

        case (state_q)
            IDLE: begin
                state_d     = COOLDOWN;
                frame_cnt_d = '0;
            end
            COOLDOWN: begin
                // Compare on the registered count so the last tick is seen
                // one cycle before arming.
                if (frame_cnt_q == gap_q) begin
                    state_d = ARMED;
                    retry_d = '0;
                end else if (upsig) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            ARMED: begin
                if (found && (cand_bucket != last_bucket_q || retry_q == RETRY_MAX)) begin
                    state_d        = SPAWN;
                    slot_oh_d      = grant;
                    initial_x_d    = cand_x;
                    spawn_bucket_d = cand_bucket;
                end else if (found) begin
                    // Only a bucket collision burns a retry; a full pool does not.
                    retry_d = retry_q + 4'd1;
                end
            end
            SPAWN: begin
                rr_ptr_d      = next_ptr(onehot_to_idx(slot_oh_q));
                last_bucket_d = spawn_bucket_q;
                if (spawn_cnt_q + 4'd1 == LEVEL_SPAWNS) begin
                    spawn_cnt_d = '0;
                    if (level_q != LEVEL_MAX) level_d = level_q + 4'd1;
                    // Compare before subtracting so the gap never wraps.
                    if (gap_q < MIN_GAP + GAP_STEP) gap_d = MIN_GAP;
                    else                            gap_d = gap_q - GAP_STEP;
                end else begin
                    spawn_cnt_d = spawn_cnt_q + 4'd1;
                end
                state_d     = COOLDOWN;
                frame_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !on) begin
            state_q        <= IDLE;
            gap_q          <= START_GAP;
            frame_cnt_q    <= '0;
            spawn_cnt_q    <= '0;
            level_q        <= '0;
            retry_q        <= '0;
            rr_ptr_q       <= '0;
            last_bucket_q  <= '0;
            spawn_bucket_q <= '0;
            slot_oh_q      <= '0;
            initial_x_q    <= '0;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            frame_cnt_q    <= frame_cnt_d;
            spawn_cnt_q    <= spawn_cnt_d;
            level_q        <= level_d;
            retry_q        <= retry_d;
            rr_ptr_q       <= rr_ptr_d;
            last_bucket_q  <= last_bucket_d;
            spawn_bucket_q <= spawn_bucket_d;
            slot_oh_q      <= slot_oh_d;
            initial_x_q    <= initial_x_d;
        end
    end

    // The strobe is gated by run so that dropping on during SPAWN kills the
    // pulse in that same cycle.
    assign init_obstacle = (state_q == SPAWN && run) ? slot_oh_q : '0;
    assign busy_stall    = (state_q == ARMED && run && !found);
    assign initial_x     = initial_x_q;
    assign level         = level_q;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Directed-plus-random bench for obstacle_spawn_scheduler. The reference
// model tracks gap, level, spawn count, round-robin pointer, last bucket and
// retry count as plain integers and predicts each spawn from the rules.
module tb_obstacle_spawn_scheduler;

    logic        clk;
    logic        reset;
    logic        on;
    logic        upsig;
    logic [18:0] q;
    logic [5:0]  obstacle_on;
    logic [5:0]  init_obstacle;
    logic [7:0]  initial_x;
    logic [3:0]  level;
    logic        busy_stall;

    int n_asserts = 0;
    int n_fail    = 0;

    // reference model
    int         m_gap, m_level, m_cnt, m_ptr, m_retry, m_total;
    logic [2:0] m_last;
    int         exp_slot;
    logic [7:0] exp_x;
    logic [2:0] exp_bucket;

    obstacle_spawn_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .on            (on),
        .upsig         (upsig),
        .q             (q),
        .obstacle_on   (obstacle_on),
        .init_obstacle (init_obstacle),
        .initial_x     (initial_x),
        .level         (level),
        .busy_stall    (busy_stall)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [5:0] occ, input int ptr);
        for (int k = 0; k < 6; k++) begin
            int s;
            s = (ptr + k) % 6;
            if (!occ[s]) return s;
        end
        return -1;
    endfunction

    function automatic logic [18:0] mk_q(input logic [2:0] b, input logic [3:0] lo);
        logic [18:0] v;
        v      = 19'($urandom);
        v[6:4] = b;
        v[3:0] = lo;
        return v;
    endfunction

    task automatic model_reset();
        m_gap = 64; m_level = 0; m_cnt = 0; m_ptr = 0; m_retry = 0; m_last = 3'd0;
    endtask

    // Starts in COOLDOWN at frame 0; ends in the first ARMED cycle.
    task automatic cooldown();
        obstacle_on = 6'h3f;
        for (int i = 0; i < m_gap; i++) begin
            upsig = 1'b1;
            tick();
            upsig = 1'b0;
            #1;
            chk("cd_no_stall", 32'(busy_stall), 32'd0);
            chk("cd_no_pulse", 32'(init_obstacle), 32'd0);
            if (i < m_gap - 1) repeat ($urandom_range(0, 1)) tick();
        end
        tick();
        #1;
        chk("cd_armed_stall", 32'(busy_stall), 32'd1);
        m_retry = 0;
    endtask

    task automatic armed_cycle(input logic [5:0] occ, input logic [18:0] qv, output bit acc);
        int s;
        obstacle_on = occ;
        q = qv;
        #1;
        s = pick(occ, m_ptr);
        chk("armed_stall", 32'(busy_stall), (s < 0) ? 32'd1 : 32'd0);
        chk("armed_no_pulse", 32'(init_obstacle), 32'd0);
        acc = 1'b0;
        if (s >= 0) begin
            if (qv[6:4] != m_last || m_retry == 15) begin
                acc = 1'b1;
                exp_slot = s;
                exp_x = {1'b0, qv[6:0]};
                exp_bucket = qv[6:4];
            end else if (m_retry < 15) begin
                m_retry++;
            end
        end
        tick();
    endtask

    task automatic spawn_cycle(input logic up);
        logic [5:0] oh;
        oh = 6'b1 << exp_slot;
        upsig = up;
        obstacle_on = 6'h3f;
        #1;
        chk("spawn_pulse", 32'(init_obstacle), 32'(oh));
        chk("spawn_x", 32'(initial_x), 32'(exp_x));
        chk("spawn_no_stall", 32'(busy_stall), 32'd0);
        m_ptr = (exp_slot + 1) % 6;
        m_last = exp_bucket;
        m_total++;
        m_cnt++;
        if (m_cnt == 8) begin
            m_cnt = 0;
            if (m_level < 15) m_level++;
            m_gap = (m_gap - 4 < 16) ? 16 : m_gap - 4;
        end
        tick();
        upsig = 1'b0;
        #1;
        chk("post_no_pulse", 32'(init_obstacle), 32'd0);
        chk("post_level", 32'(level), 32'(m_level));
        chk("post_x_hold", 32'(initial_x), 32'(exp_x));
    endtask

    task automatic spawn_run();
        bit acc;
        logic [5:0] occ;
        logic [18:0] qv;
        cooldown();
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            occ = (k < 6) ? 6'($urandom_range(0, 63)) : 6'd0;
            qv = 19'($urandom);
            if ($urandom_range(0, 2) == 0) qv[6:4] = m_last;
            armed_cycle(occ, qv, acc);
        end
        chk("arm_timeout", 32'(acc), 32'd1);
        if (acc) spawn_cycle(1'($urandom_range(0, 1)));
    endtask

    initial begin
        bit acc;
        logic [5:0] occ;
        logic [2:0] b;

        reset = 1'b1; on = 1'b1; upsig = 1'b0; q = '0; obstacle_on = '0;
        m_total = 0;
        model_reset();
        repeat (3) tick();
        chk("rst_init", 32'(init_obstacle), 32'd0);
        chk("rst_x", 32'(initial_x), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_stall", 32'(busy_stall), 32'd0);
        reset = 1'b0;
        tick();  // IDLE -> COOLDOWN

        // First spawn: all slots free, bucket 3
        cooldown();
        armed_cycle(6'd0, 19'h00035, acc);
        chk("a_first_pulse", 32'(init_obstacle), 32'h01);
        chk("a_first_x", 32'(initial_x), 32'h35);
        spawn_cycle(1'b0);

        // Slots never clear: spawns land on 1..5 in order
        occ = 6'b000001;
        for (int s = 1; s < 6; s++) begin
            b = 3'((3 + s) % 8);
            cooldown();
            armed_cycle(occ, mk_q(b, 4'(s)), acc);
            chk("b_order", 32'(init_obstacle), 32'(6'b1 << s));
            spawn_cycle(1'b0);
            occ = occ | (6'b1 << s);
        end
        // Seventh arm: full pool stalls, then slot 3 frees
        cooldown();
        b = m_last + 3'd1;
        repeat (3) armed_cycle(6'h3f, mk_q(b, 4'd7), acc);
        armed_cycle(6'b110111, mk_q(b, 4'd7), acc);
        chk("b_slot3", 32'(init_obstacle), 32'h08);
        spawn_cycle(1'b1);  // upsig coincident with SPAWN is not counted

        // Bucket collision forces acceptance on the 16th ARMED cycle
        cooldown();
        acc = 1'b0;
        for (int k = 0; k < 16 && !acc; k++) armed_cycle(6'd0, mk_q(m_last, 4'(k)), acc);
        chk("c_forced", 32'(init_obstacle), 32'h10);
        spawn_cycle(1'b0);
        chk("c_level1", 32'(level), 32'd1);

        // Random spawns up to 96 total, then one more at the gap floor
        while (m_total < 96) spawn_run();
        chk("d_level12", 32'(level), 32'd12);
        spawn_run();

        // on dropped while ARMED
        cooldown();
        on = 1'b0;
        obstacle_on = 6'd0;
        q = mk_q(m_last + 3'd1, 4'd1);
        tick();
        chk("e_init", 32'(init_obstacle), 32'd0);
        chk("e_x", 32'(initial_x), 32'd0);
        chk("e_level", 32'(level), 32'd0);
        chk("e_stall", 32'(busy_stall), 32'd0);
        on = 1'b1;
        model_reset();
        tick();
        cooldown();  // full 64-frame cooldown
        armed_cycle(6'd0, mk_q(3'd5, 4'd9), acc);
        chk("e_restart_pulse", 32'(init_obstacle), 32'h01);
        spawn_cycle(1'b0);

        // on dropped during SPAWN
        cooldown();
        armed_cycle(6'd0, mk_q(m_last + 3'd2, 4'd3), acc);
        on = 1'b0;
        #1;
        chk("f_suppress", 32'(init_obstacle), 32'd0);
        tick();
        chk("f_init", 32'(init_obstacle), 32'd0);
        chk("f_x", 32'(initial_x), 32'd0);
        chk("f_level", 32'(level), 32'd0);
        on = 1'b1;
        model_reset();
        tick();
        spawn_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
